// File: rtl/semaforo_pkg.sv
// Shared definitions for the two-approach intersection phase scheduler.
// Contents: phase enum, one-hot light encodings, config selector codes,
// default durations and small decode helpers used by the controller.
package semaforo_pkg;

  typedef enum logic [2:0] {
    AG   = 3'd0,  // approach A green
    AY   = 3'd1,  // approach A yellow
    CLR1 = 3'd2,  // all-red clearance after A
    BG   = 3'd3,  // approach B green
    BY   = 3'd4,  // approach B yellow
    CLR2 = 3'd5   // all-red clearance after B
  } state_t;

  typedef enum logic [1:0] {
    SEL_VERDE_A  = 2'd0,
    SEL_VERDE_B  = 2'd1,
    SEL_AMARELO  = 2'd2,
    SEL_VERMELHO = 2'd3
  } cfg_sel_t;

  localparam logic [2:0] LUZ_VERDE    = 3'b100;
  localparam logic [2:0] LUZ_AMARELO  = 3'b010;
  localparam logic [2:0] LUZ_VERMELHO = 3'b001;

  localparam int DEF_CNT_W      = 8;
  localparam int DEF_VERDE      = 3;
  localparam int DEF_AMARELO    = 1;
  localparam int DEF_VERMELHO   = 2;
  localparam int DEF_MIN_GREEN  = 1;

  // Fixed phase rotation: AG -> AY -> CLR1 -> BG -> BY -> CLR2 -> AG.
  function automatic state_t next_phase(input state_t s);
    case (s)
      AG:      next_phase = AY;
      AY:      next_phase = CLR1;
      CLR1:    next_phase = BG;
      BG:      next_phase = BY;
      BY:      next_phase = CLR2;
      default: next_phase = AG;
    endcase
  endfunction

  function automatic logic [2:0] luz_a(input state_t s);
    case (s)
      AG:      luz_a = LUZ_VERDE;
      AY:      luz_a = LUZ_AMARELO;
      default: luz_a = LUZ_VERMELHO;
    endcase
  endfunction

  function automatic logic [2:0] luz_b(input state_t s);
    case (s)
      BG:      luz_b = LUZ_VERDE;
      BY:      luz_b = LUZ_AMARELO;
      default: luz_b = LUZ_VERMELHO;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase duration timer.
// A loadable down-counter reports o_done when it reaches zero; an elapsed
// counter, cleared on load and saturating at MIN_GREEN, reports o_min_ok
// once the phase has run at least MIN_GREEN cycles.
// Ports: clk, rst_n (async, active-low), i_load, i_load_val, o_done, o_min_ok.
module phase_timer #(
  parameter int              CNT_W     = 8,
  parameter int              MIN_GREEN = 1,
  parameter logic [CNT_W-1:0] RST_CNT  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done,
  output logic             o_min_ok
);

  localparam logic [CNT_W-1:0] MIN_EL = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_elapsed;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= RST_CNT;
      r_elapsed <= '0;
    end else if (i_load) begin
      r_cnt     <= i_load_val;
      r_elapsed <= '0;
    end else begin
      if (r_cnt != '0)       r_cnt     <= r_cnt - ONE;
      if (r_elapsed < MIN_EL) r_elapsed <= r_elapsed + ONE;
    end
  end

  assign o_done   = (r_cnt == '0);
  assign o_min_ok = (r_elapsed >= MIN_EL);

endmodule

// File: rtl/semaforo_sched.sv
// Two-approach intersection phase scheduler (top level).
// Sequences green/yellow/all-red phases from programmable durations, latches
// pedestrian requests, truncates the conflicting green once MIN_GREEN cycles
// have elapsed, and drives registered light heads and walk indicators.
// Ports: clk, rst (async, active-low), bt_a/bt_b push buttons,
//        cfg_we/cfg_sel/cfg_data duration writes, A/B one-hot lights,
//        walk_a/walk_b pedestrian indicators.
module semaforo_sched
  import semaforo_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int T_VERDE    = DEF_VERDE,
  parameter int T_AMARELO  = DEF_AMARELO,
  parameter int T_VERMELHO = DEF_VERMELHO,
  parameter int MIN_GREEN  = DEF_MIN_GREEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bt_a,
  input  logic             bt_b,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_data,
  output logic [2:0]       A,
  output logic [2:0]       B,
  output logic             walk_a,
  output logic             walk_b
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           r_state, w_next_state;
  logic             w_advance, w_trunc, w_done, w_min_ok;
  logic [CNT_W-1:0] w_load_val, w_cfg_val;
  logic [CNT_W-1:0] r_dur_ga, r_dur_gb, r_dur_y, r_dur_clr;
  logic             r_req_a, r_req_b, r_walk_a, r_walk_b;
  logic [2:0]       r_luz_a, r_luz_b;
  logic             w_enter_ag, w_enter_bg, w_leave_ag, w_leave_bg;

  phase_timer #(
    .CNT_W     (CNT_W),
    .MIN_GREEN (MIN_GREEN),
    .RST_CNT   (CNT_W'(T_VERDE - 1))
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst),
    .i_load     (w_advance),
    .i_load_val (w_load_val),
    .o_done     (w_done),
    .o_min_ok   (w_min_ok)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= AG;
    else      r_state <= w_next_state;
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_load_val   = '0;
    // A pending crossing request cuts the conflicting green short.
    w_trunc   = w_min_ok && (((r_state == AG) && r_req_a) ||
                             ((r_state == BG) && r_req_b));
    w_advance = w_done || w_trunc;
    if (w_advance) w_next_state = next_phase(r_state);
    // Load uses the duration registers as they stand before this edge, so a
    // write landing on an entry edge only affects the following entry.
    case (w_next_state)
      AG:       w_load_val = r_dur_ga - ONE;
      BG:       w_load_val = r_dur_gb - ONE;
      AY, BY:   w_load_val = r_dur_y - ONE;
      default:  w_load_val = r_dur_clr - ONE;
    endcase
  end

  assign w_enter_ag = w_advance && (w_next_state == AG);
  assign w_enter_bg = w_advance && (w_next_state == BG);
  assign w_leave_ag = w_advance && (r_state == AG);
  assign w_leave_bg = w_advance && (r_state == BG);

  // Lights are registered from the next state so they change on the same
  // edge as the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_luz_a <= LUZ_VERDE;
      r_luz_b <= LUZ_VERMELHO;
    end else begin
      r_luz_a <= luz_a(w_next_state);
      r_luz_b <= luz_b(w_next_state);
    end
  end

  // A press sampled on the entry edge is served in that phase; service has
  // priority over setting, so the request never survives its own crossing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_a  <= 1'b0;
      r_req_b  <= 1'b0;
      r_walk_a <= 1'b0;
      r_walk_b <= 1'b0;
    end else begin
      if (w_enter_bg)      r_walk_a <= r_req_a | bt_a;
      else if (w_leave_bg) r_walk_a <= 1'b0;
      if (w_enter_ag)      r_walk_b <= r_req_b | bt_b;
      else if (w_leave_ag) r_walk_b <= 1'b0;

      if (w_enter_bg) r_req_a <= 1'b0;
      else if (bt_a)  r_req_a <= 1'b1;
      if (w_enter_ag) r_req_b <= 1'b0;
      else if (bt_b)  r_req_b <= 1'b1;
    end
  end

  // A zero duration would stall the counter semantics; store it as 1.
  assign w_cfg_val = (cfg_data == '0) ? ONE : cfg_data;

  // NOTE: the duration registers are reset like any other state because a
  // reset must discard programmed timing and fall back to the defaults.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dur_ga  <= CNT_W'(T_VERDE);
      r_dur_gb  <= CNT_W'(T_VERDE);
      r_dur_y   <= CNT_W'(T_AMARELO);
      r_dur_clr <= CNT_W'(T_VERMELHO);
    end else if (cfg_we) begin
      case (cfg_sel_t'(cfg_sel))
        SEL_VERDE_A:  r_dur_ga  <= w_cfg_val;
        SEL_VERDE_B:  r_dur_gb  <= w_cfg_val;
        SEL_AMARELO:  r_dur_y   <= w_cfg_val;
        default:      r_dur_clr <= w_cfg_val;
      endcase
    end
  end

  assign A      = r_luz_a;
  assign B      = r_luz_b;
  assign walk_a = r_walk_a;
  assign walk_b = r_walk_b;

endmodule

// File: tb/tb_semaforo_sched.sv
// Self-checking bench for semaforo_sched: directed scenarios plus random
// buttons and config writes, compared cycle by cycle with a phase-table
// reference model that counts cycles spent in the current phase.
module tb_semaforo_sched;

  localparam int MIN_GREEN = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       bt_a, bt_b, cfg_we;
  logic [1:0] cfg_sel;
  logic [7:0] cfg_data;
  logic [2:0] A, B;
  logic       walk_a, walk_b;

  int n_checks = 0;
  int n_errors = 0;

  semaforo_sched #(
    .CNT_W(8), .T_VERDE(3), .T_AMARELO(1), .T_VERMELHO(2), .MIN_GREEN(MIN_GREEN)
  ) dut (
    .clk(clk), .rst(rst), .bt_a(bt_a), .bt_b(bt_b),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .A(A), .B(B), .walk_a(walk_a), .walk_b(walk_b)
  );

  always #5 clk = ~clk;

  // Reference model: phase index 0..5 = AG, AY, CLR1, BG, BY, CLR2.
  localparam logic [2:0] LA [6] = '{3'b100, 3'b010, 3'b001, 3'b001, 3'b001, 3'b001};
  localparam logic [2:0] LB [6] = '{3'b001, 3'b001, 3'b001, 3'b100, 3'b010, 3'b001};
  // Which duration register governs each phase: 0 green A, 1 green B, 2 yellow, 3 clearance.
  localparam int DUR_OF [6] = '{0, 2, 3, 1, 2, 3};

  int   m_ph, m_age, m_len;
  int   m_dur [4];
  logic m_req_a, m_req_b, m_walk_a, m_walk_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_age = 0; m_len = 3;
    m_dur[0] = 3; m_dur[1] = 3; m_dur[2] = 1; m_dur[3] = 2;
    m_req_a = 1'b0; m_req_b = 1'b0; m_walk_a = 1'b0; m_walk_b = 1'b0;
  endtask

  task automatic model_step(input logic ba, input logic bb, input logic we,
                            input logic [1:0] sel, input logic [7:0] data);
    logic leaving, trunc;
    int   nph;
    trunc   = ((m_ph == 0) && m_req_a && (m_age >= MIN_GREEN)) ||
              ((m_ph == 3) && m_req_b && (m_age >= MIN_GREEN));
    leaving = (m_age + 1 >= m_len) || trunc;
    nph     = leaving ? (m_ph + 1) % 6 : m_ph;
    if (leaving && nph == 3)      m_walk_a = m_req_a | ba;
    else if (leaving && m_ph == 3) m_walk_a = 1'b0;
    if (leaving && nph == 0)      m_walk_b = m_req_b | bb;
    else if (leaving && m_ph == 0) m_walk_b = 1'b0;
    if (leaving && nph == 3) m_req_a = 1'b0; else if (ba) m_req_a = 1'b1;
    if (leaving && nph == 0) m_req_b = 1'b0; else if (bb) m_req_b = 1'b1;
    if (leaving) begin
      m_len = m_dur[DUR_OF[nph]];
      m_age = 0;
    end else begin
      m_age++;
    end
    if (we) m_dur[sel] = (data == 8'd0) ? 1 : int'(data);
    m_ph = nph;
  endtask

  // Called at a falling edge: check outputs, drive inputs, advance the model.
  task automatic cycle(input logic ba, input logic bb, input logic we,
                       input logic [1:0] sel, input logic [7:0] data);
    check("light_a", 32'(A), 32'(LA[m_ph]));
    check("light_b", 32'(B), 32'(LB[m_ph]));
    check("walk_a", 32'(walk_a), 32'(m_walk_a));
    check("walk_b", 32'(walk_b), 32'(m_walk_b));
    check("never_both_open", 32'((A == 3'b001) || (B == 3'b001)), 32'd1);
    check("walk_only_red", 32'((!walk_a || A == 3'b001) && (!walk_b || B == 3'b001)), 32'd1);
    bt_a = ba; bt_b = bb; cfg_we = we; cfg_sel = sel; cfg_data = data;
    model_step(ba, bb, we, sel, data);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
  endtask

  // Asynchronous reset between clock edges; outputs must react without an edge.
  task automatic do_reset();
    bt_a = 1'b0; bt_b = 1'b0; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_data = 8'd0;
    #2 rst = 1'b0;
    #1;
    check("rst_light_a", 32'(A), 32'h4);
    check("rst_light_b", 32'(B), 32'h1);
    check("rst_walk_a", 32'(walk_a), 32'd0);
    check("rst_walk_b", 32'(walk_b), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    bt_a = 1'b0; bt_b = 1'b0; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_data = 8'd0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Default timing, no requests.
    idle(14);

    // Single press truncates AG and opens the A crossing during BG.
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    idle(14);

    // Green B = 5 and yellow written as 0 (stored as 1).
    do_reset();
    cycle(1'b0, 1'b0, 1'b1, 2'd1, 8'd5);
    cycle(1'b0, 1'b0, 1'b1, 2'd2, 8'd0);
    idle(20);

    // Both buttons in the same AG cycle.
    do_reset();
    idle(1);
    cycle(1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
    idle(20);

    // Program green A = 7, reach BG with walk_a, then reset mid-BG.
    do_reset();
    cycle(1'b0, 1'b0, 1'b1, 2'd0, 8'd7);
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    for (int i = 0; i < 40; i++) begin
      if (m_ph == 3 && m_walk_a) break;
      idle(1);
    end
    idle(1);
    do_reset();
    idle(8);

    // Button A held for 40 cycles.
    do_reset();
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    idle(10);

    // Random buttons and config writes.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      cycle(logic'($urandom_range(5) == 0), logic'($urandom_range(5) == 0),
            logic'($urandom_range(11) == 0), 2'($urandom_range(3)),
            8'($urandom_range(5)));
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
